id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage that directly feeds the execute ALU.
- Each cycle it captures a decoded instruction, then drives the ALU's `a`, `b` and 4-bit `alu_ctrl` inputs.
- Operands are forwarded from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles; honours pipeline stall and flush.

Parameters:
- XLEN, 32, datapath width
- RAW, 5, register-address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs1, id_rs2  in  RAW  source register addresses
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_alu_src  in  1  1 selects immediate as ALU b operand
- id_alu_ctrl  in  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- id_rd  in  RAW  destination register
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
- stall  in  1  freeze the whole pipeline (hold contents)
- flush  in  1  kill the instruction entering EX
- exmem_rd  in  RAW; exmem_reg_write  in  1; exmem_result  in  XLEN
- memwb_rd  in  RAW; memwb_reg_write  in  1; memwb_result  in  XLEN
- alu_a, alu_b  out  XLEN  ALU operands (combinational from registered state + forwarding)
- alu_ctrl  out  4  registered ALU op
- ex_store_data  out  XLEN  forwarded rs2 value for stores
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered control
- ex_rd  out  RAW  registered destination
- load_use_stall  out  1  combinational request to hold IF/ID

Behaviour:
- Reset: every register cleared to 0.
  - ex_valid and all control outputs are 0; alu_ctrl is 0000; ex_rd is 0.
  - alu_a and alu_b read 0 unless forwarding matches.
- load_use_stall = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
- Update priority at each clock edge, highest first:
  1. rst: clear all.
  2. flush: load a bubble.
  3. stall: hold all registers.
  4. load_use_stall: load a bubble.
  5. Otherwise: capture all id_* fields, with ex_valid = id_valid.
- Bubble contents:
  - ex_valid, reg_write, mem_read, mem_write and mem_to_reg are 0.
  - alu_ctrl is 0000 and ex_rd is 0.
  - Data fields may be don't-care, but the bench expects 0.
- Capturing with id_valid = 0 also zeroes all control bits.
- Latency: one cycle from id_* to registered outputs; forwarding is zero-cycle combinational.
- Forwarding, applied per operand (rs1 → fa, rs2 → fb):
  - Take exmem_result if exmem_reg_write & exmem_rd != 0 & exmem_rd == rs.
  - Else take memwb_result if memwb_reg_write & memwb_rd != 0 & memwb_rd == rs.
  - Else take the registered rs data.
  - EX/MEM always wins when both stages match.
  - Register x0 is never forwarded.
- Operand outputs:
  - alu_a = fa.
  - alu_b = ex_alu_src ? ex_imm : fb.
  - ex_store_data = fb, regardless of alu_src.
- Forwarding is evaluated even when ex_valid = 0; downstream must qualify on ex_valid.
- Boundary conditions:
  - flush and stall together: flush wins.
  - stall and load_use_stall together: hold, no bubble.
  - The hazard self-clears after the bubble, because ex_mem_read drops.
- Reset mid-operation discards the in-flight instruction the same edge.
- No arithmetic is performed here; widths pass through unchanged.

Test Plan:
- Reset, then ADD with rs1 data 5, rs2 data 7, alu_src=0 → next cycle alu_a=5, alu_b=7, alu_ctrl=0010, ex_valid=1.
- Immediate form: alu_src=1, imm=0xFFFFFFFC, rs2 data 9 → alu_b=0xFFFFFFFC and ex_store_data=9.
- Forwarding priority: EX rs1=3; exmem_rd=3 result 0x11; memwb_rd=3 result 0x22 → alu_a=0x11.
  - Drop exmem_reg_write → alu_a=0x22.
  - Same with rd=0 → registered data used.
- Load-use: EX holds lw with rd=4; ID instruction uses rs2=4 → load_use_stall=1.
  - Next edge: ex_valid=0 and control bits all 0.
  - Following cycle: load_use_stall=0.
- Stall then flush:
  - Assert stall for 3 cycles → outputs unchanged.
  - Assert stall and flush together → bubble.
  - Assert rst with a valid instruction in flight → all outputs 0 next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Drives the execute ALU operands, op code and registered control for later stages.
module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int RAW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [RAW-1:0]  id_rs1,
   input  logic [RAW-1:0]  id_rs2,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic            id_alu_src,
   input  logic [3:0]      id_alu_ctrl,
   input  logic [RAW-1:0]  id_rd,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            id_mem_to_reg,
   input  logic            stall,
   input  logic            flush,
   input  logic [RAW-1:0]  exmem_rd,
   input  logic            exmem_reg_write,
   input  logic [XLEN-1:0] exmem_result,
   input  logic [RAW-1:0]  memwb_rd,
   input  logic            memwb_reg_write,
   input  logic [XLEN-1:0] memwb_result,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_ctrl,
   output logic [XLEN-1:0] ex_store_data,
   output logic            ex_valid,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_mem_to_reg,
   output logic [RAW-1:0]  ex_rd,
   output logic            load_use_stall
);

   logic            valid_q, valid_d;
   logic            reg_write_q, reg_write_d;
   logic            mem_read_q, mem_read_d;
   logic            mem_write_q, mem_write_d;
   logic            mem_to_reg_q, mem_to_reg_d;
   logic            alu_src_q, alu_src_d;
   logic [3:0]      alu_ctrl_q, alu_ctrl_d;
   logic [RAW-1:0]  rd_q, rd_d;
   logic [RAW-1:0]  rs1_q, rs1_d;
   logic [RAW-1:0]  rs2_q, rs2_d;
   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] rs2_data_q, rs2_data_d;
   logic [XLEN-1:0] imm_q, imm_d;

   logic [XLEN-1:0] fa, fb;

   assign load_use_stall = valid_q & mem_read_q & (rd_q != '0) & id_valid &
                           ((rd_q == id_rs1) | (rd_q == id_rs2));

   always_comb begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_to_reg_d = mem_to_reg_q;
      alu_src_d    = alu_src_q;
      alu_ctrl_d   = alu_ctrl_q;
      rd_d         = rd_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      rs1_data_d   = rs1_data_q;
      rs2_data_d   = rs2_data_q;
      imm_d        = imm_q;
      // A bubble is all zeros, data included, so it never forwards anything.
      if (flush || (!stall && load_use_stall)) begin
         valid_d      = 1'b0;
         reg_write_d  = 1'b0;
         mem_read_d   = 1'b0;
         mem_write_d  = 1'b0;
         mem_to_reg_d = 1'b0;
         alu_src_d    = 1'b0;
         alu_ctrl_d   = 4'b0000;
         rd_d         = '0;
         rs1_d        = '0;
         rs2_d        = '0;
         rs1_data_d   = '0;
         rs2_data_d   = '0;
         imm_d        = '0;
      end else if (!stall) begin
         valid_d      = id_valid;
         reg_write_d  = id_valid & id_reg_write;
         mem_read_d   = id_valid & id_mem_read;
         mem_write_d  = id_valid & id_mem_write;
         mem_to_reg_d = id_valid & id_mem_to_reg;
         alu_src_d    = id_alu_src;
         alu_ctrl_d   = id_alu_ctrl;
         rd_d         = id_rd;
         rs1_d        = id_rs1;
         rs2_d        = id_rs2;
         rs1_data_d   = id_rs1_data;
         rs2_data_d   = id_rs2_data;
         imm_d        = id_imm;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         alu_src_q    <= 1'b0;
         alu_ctrl_q   <= 4'b0000;
         rd_q         <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rs1_data_q   <= '0;
         rs2_data_q   <= '0;
         imm_q        <= '0;
      end else begin
         valid_q      <= valid_d;
         reg_write_q  <= reg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         alu_src_q    <= alu_src_d;
         alu_ctrl_q   <= alu_ctrl_d;
         rd_q         <= rd_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         rs1_data_q   <= rs1_data_d;
         rs2_data_q   <= rs2_data_d;
         imm_q        <= imm_d;
      end
   end

   // EX/MEM is younger than MEM/WB, so it wins; x0 is hardwired and never forwarded.
   always_comb begin
      fa = rs1_data_q;
      if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_q))
         fa = exmem_result;
      else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_q))
         fa = memwb_result;
   end

   always_comb begin
      fb = rs2_data_q;
      if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_q))
         fb = exmem_result;
      else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_q))
         fb = memwb_result;
   end

   assign alu_a         = fa;
   assign alu_b         = alu_src_q ? imm_q : fb;
   assign ex_store_data = fb;
   assign alu_ctrl      = alu_ctrl_q;
   assign ex_valid      = valid_q;
   assign ex_reg_write  = reg_write_q;
   assign ex_mem_read   = mem_read_q;
   assign ex_mem_write  = mem_write_q;
   assign ex_mem_to_reg = mem_to_reg_q;
   assign ex_rd         = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: capture, immediate select,
// forwarding priority, load-use bubbles, stall/flush priority and reset.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic        id_alu_src;
   logic [3:0]  id_alu_ctrl;
   logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic        stall, flush;
   logic [4:0]  exmem_rd, memwb_rd;
   logic        exmem_reg_write, memwb_reg_write;
   logic [31:0] exmem_result, memwb_result;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [3:0]  alu_ctrl;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic [4:0]  ex_rd;
   logic        load_use_stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32), .RAW(5)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
      .stall(stall), .flush(flush),
      .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
      .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
      .load_use_stall(load_use_stall)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                           input logic src, input logic [3:0] op, input logic [4:0] rd,
                           input logic rw, input logic mr, input logic mw, input logic m2r);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_data = d1; id_rs2_data = d2;
      id_imm = imm; id_alu_src = src; id_alu_ctrl = op; id_rd = rd;
      id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, " ex_valid"},   32'(ex_valid), 32'd0);
      check({tag, " ctrl bits"},  32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'd0);
      check({tag, " alu_ctrl"},   32'(alu_ctrl), 32'd0);
      check({tag, " ex_rd"},      32'(ex_rd), 32'd0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      drive_id(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      exmem_rd = 5'd0; exmem_reg_write = 1'b0; exmem_result = 32'd0;
      memwb_rd = 5'd0; memwb_reg_write = 1'b0; memwb_result = 32'd0;
      step(); step();
      rst = 1'b0;
      check_bubble("reset");
      check("reset alu_a", alu_a, 32'd0);
      check("reset alu_b", alu_b, 32'd0);

      // ADD x3 = x1 + x2
      drive_id(1'b1, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 4'b0010, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check("add alu_a", alu_a, 32'd5);
      check("add alu_b", alu_b, 32'd7);
      check("add alu_ctrl", 32'(alu_ctrl), 32'h2);
      check("add ex_valid", 32'(ex_valid), 32'd1);
      check("add ex_rd", 32'(ex_rd), 32'd3);
      check("add reg_write", 32'(ex_reg_write), 32'd1);

      // Immediate form
      drive_id(1'b1, 5'd1, 5'd2, 32'd1, 32'd9, 32'hFFFF_FFFC, 1'b1, 4'b0010, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check("imm alu_b", alu_b, 32'hFFFF_FFFC);
      check("imm store_data", ex_store_data, 32'd9);
      check("imm alu_a", alu_a, 32'd1);

      // Forwarding priority on rs1=3, rs2=6
      drive_id(1'b1, 5'd3, 5'd6, 32'h33, 32'h66, 32'd0, 1'b0, 4'b0110, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      exmem_rd = 5'd3; exmem_reg_write = 1'b1; exmem_result = 32'h11;
      memwb_rd = 5'd3; memwb_reg_write = 1'b1; memwb_result = 32'h22;
      #1;
      check("fwd exmem wins", alu_a, 32'h11);
      check("fwd rs2 untouched", alu_b, 32'h66);
      exmem_reg_write = 1'b0; #1;
      check("fwd memwb", alu_a, 32'h22);
      memwb_reg_write = 1'b0; #1;
      check("fwd none", alu_a, 32'h33);
      memwb_rd = 5'd6; memwb_reg_write = 1'b1; memwb_result = 32'h5A; #1;
      check("fwd store_data memwb", ex_store_data, 32'h5A);
      check("fwd alu_b memwb", alu_b, 32'h5A);
      // x0 source must never be forwarded
      drive_id(1'b1, 5'd0, 5'd0, 32'h44, 32'h55, 32'd0, 1'b0, 4'b0001, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      exmem_rd = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'h11;
      memwb_rd = 5'd0; memwb_reg_write = 1'b1; memwb_result = 32'h22;
      #1;
      check("fwd x0 rs1", alu_a, 32'h44);
      check("fwd x0 rs2", alu_b, 32'h55);
      exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

      // Load-use: lw x4, then consumer reading rs2=4
      drive_id(1'b1, 5'd1, 5'd0, 32'h100, 32'd0, 32'd8, 1'b1, 4'b0010, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
      drive_id(1'b1, 5'd5, 5'd4, 32'd1, 32'd2, 32'd0, 1'b0, 4'b0000, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      check("lu stall asserted", 32'(load_use_stall), 32'd1);
      step();
      check_bubble("lu bubble");
      check("lu bubble alu_a", alu_a, 32'd0);
      check("lu stall cleared", 32'(load_use_stall), 32'd0);
      step();
      check("lu consumer captured rd", 32'(ex_rd), 32'd7);
      check("lu consumer valid", 32'(ex_valid), 32'd1);

      // stall together with load-use hazard: hold, no bubble
      drive_id(1'b1, 5'd1, 5'd0, 32'h100, 32'd0, 32'd8, 1'b1, 4'b0010, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
      drive_id(1'b1, 5'd4, 5'd2, 32'd3, 32'd4, 32'd0, 1'b0, 4'b0111, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      stall = 1'b1;
      #1;
      check("stall+lu request", 32'(load_use_stall), 32'd1);
      step();
      check("stall+lu hold mem_read", 32'(ex_mem_read), 32'd1);
      check("stall+lu hold rd", 32'(ex_rd), 32'd4);
      stall = 1'b0;
      step();
      check_bubble("lu after stall");
      step();
      check("slt captured rd", 32'(ex_rd), 32'd8);
      check("slt alu_ctrl", 32'(alu_ctrl), 32'h7);

      // Stall three cycles with different ID contents
      drive_id(1'b1, 5'd10, 5'd11, 32'hAA, 32'hBB, 32'd0, 1'b0, 4'b0001, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("stall%0d ex_rd", i), 32'(ex_rd), 32'd8);
         check($sformatf("stall%0d alu_a", i), alu_a, 32'd3);
         check($sformatf("stall%0d alu_ctrl", i), 32'(alu_ctrl), 32'h7);
      end
      flush = 1'b1;
      step();
      check_bubble("stall+flush");
      stall = 1'b0; flush = 1'b0;

      // Reset with a valid instruction in flight
      step();
      check("pre-reset valid", 32'(ex_valid), 32'd1);
      check("pre-reset mem_write", 32'(ex_mem_write), 32'd1);
      rst = 1'b1;
      step();
      check_bubble("mid reset");
      check("mid reset alu_a", alu_a, 32'd0);
      check("mid reset alu_b", alu_b, 32'd0);
      check("mid reset store", ex_store_data, 32'd0);
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
